// File: rtl/i281_code_loader.sv
// i281 code loader: byte-stream framer that writes a program image into code memory.
// Frame = header (N-1), 2N data bytes (hi, lo), XOR checksum of the data bytes.
module i281_code_loader #(
    parameter int ADDR_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              run_en,
    output logic              busy,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_in_ready;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic [5:0]        r_cnt;
    logic [7:0]        r_hi;
    logic [7:0]        r_acc;
    logic              r_error;
    logic              w_acc;
    logic              w_busy_next;

    assign w_acc = in_valid & r_in_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_HDR;
            S_HDR:  if (w_acc) w_next = S_HI;
            S_HI:   if (w_acc) w_next = S_LO;
            S_LO:   if (w_acc) w_next = (r_cnt == 6'd0) ? S_CHK : S_HI;
            S_CHK:  if (w_acc) w_next = S_DONE;
            S_DONE: if (start) w_next = S_HDR;
            default: w_next = S_IDLE;
        endcase
    end

    assign w_busy_next = (w_next == S_HDR) || (w_next == S_HI) ||
                         (w_next == S_LO)  || (w_next == S_CHK);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_in_ready <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_hi       <= '0;
            r_acc      <= '0;
            r_error    <= 1'b0;
        end else begin
            r_in_ready <= w_busy_next;
            r_wr_en    <= (r_state == S_LO) && w_acc;
            // Advance only when another word follows, so N=64 parks at 63
            if (r_wr_en && r_state == S_HI)
                r_addr <= r_addr + 1'b1;
            if (r_state == S_HDR && w_acc) begin
                r_cnt  <= in_data[5:0];
                r_addr <= '0;
                r_acc  <= '0;
            end
            if (r_state == S_HI && w_acc) begin
                r_hi  <= in_data;
                r_acc <= r_acc ^ in_data;
            end
            if (r_state == S_LO && w_acc) begin
                r_data <= {r_hi, in_data};
                r_acc  <= r_acc ^ in_data;
                if (r_cnt != 6'd0) r_cnt <= r_cnt - 6'd1;
            end
            if (r_state == S_CHK && w_acc)
                r_error <= (r_acc != in_data);
            if (r_state == S_DONE && start)
                r_error <= 1'b0;
        end
    end

    assign in_ready = r_in_ready;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_addr;
    assign wr_data  = r_data;
    assign busy     = (r_state == S_HDR) || (r_state == S_HI) ||
                      (r_state == S_LO)  || (r_state == S_CHK);
    assign done     = (r_state == S_DONE);
    assign error    = r_error;
    assign run_en   = (r_state == S_IDLE) || ((r_state == S_DONE) && !r_error);

endmodule

// File: tb/tb_i281_code_loader.sv
// Scoreboard bench for i281_code_loader: frame-level model queues expected
// writes and checksum verdicts; a monitor compares them as the DUT emits.
module tb_i281_code_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        run_en;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    bit prev_done = 1'b0;

    logic [21:0] wq[$];
    bit          eq[$];
    logic [15:0] img[$];

    always #5 clock = ~clock;

    i281_code_loader #(.ADDR_W(6)) dut (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .run_en(run_en), .busy(busy), .done(done), .error(error)
    );

    always @(negedge clock) begin
        if (!reset) begin
            prev_done = 1'b0;
        end else begin
            if (wr_en) begin
                wr_seen++;
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected addr=%0d data=%h", wr_addr, wr_data);
                end else begin
                    logic [21:0] e;
                    e = wq.pop_front();
                    if ({wr_addr, wr_data} !== e) begin
                        errors++;
                        $display("FAIL wr_cmp got addr=%0d data=%h exp addr=%0d data=%h",
                                 wr_addr, wr_data, e[21:16], e[15:0]);
                    end
                end
            end
            if (busy) begin
                checks++;
                if (run_en !== 1'b0) begin
                    errors++;
                    $display("FAIL run_en_busy got=%b exp=0", run_en);
                end
            end
            if (done && !prev_done) begin
                checks++;
                if (eq.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected error=%b", error);
                end else begin
                    bit ee;
                    ee = eq.pop_front();
                    if (error !== ee || run_en !== !ee) begin
                        errors++;
                        $display("FAIL verdict got err=%b run_en=%b exp err=%b run_en=%b",
                                 error, run_en, ee, !ee);
                    end
                end
            end
            prev_done = done;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_run_en", run_en, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bit ok;
        t = 0;
        ok = 1'b0;
        in_data = b;
        in_valid = 1'b1;
        while (!ok && t < 300) begin
            @(negedge clock);
            if (in_ready) ok = 1'b1;
            else t++;
        end
        if (!ok) begin
            errors++;
            $display("FAIL accept_timeout byte=%h", b);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 500) begin
            @(posedge clock); #1;
            t++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout got=0 exp=1");
        end
        @(posedge clock); #1;
        chk("wq_drained", wq.size(), 0);
        chk("eq_drained", eq.size(), 0);
    endtask

    // Model: word i goes to address i; checksum is XOR of all data bytes.
    task automatic run_frame(input logic [7:0] hdr, input logic [7:0] c,
                             input int gap, input bit start_lo);
        int n;
        logic [7:0] acc;
        n = int'(hdr[5:0]) + 1;
        acc = 8'h00;
        for (int i = 0; i < n; i++) begin
            wq.push_back({i[5:0], img[i]});
            acc = acc ^ img[i][15:8] ^ img[i][7:0];
        end
        eq.push_back(c != acc);
        do_start();
        send_byte(hdr, gap);
        for (int i = 0; i < n; i++) begin
            send_byte(img[i][15:8], gap);
            if (start_lo && i == 0) start = 1'b1;
            send_byte(img[i][7:0], gap);
            start = 1'b0;
        end
        send_byte(c, gap);
        wait_done();
    endtask

    function automatic logic [7:0] img_xor(input int n);
        logic [7:0] a;
        a = 8'h00;
        for (int i = 0; i < n; i++) a = a ^ img[i][15:8] ^ img[i][7:0];
        return a;
    endfunction

    initial begin
        int n;
        int snap;
        logic [7:0] h;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals();
        reset = 1'b1;
        @(posedge clock); #1;
        chk("idle_in_ready", in_ready, 0);

        img = '{16'h1234};
        run_frame(8'h00, 8'h26, 0, 1'b0);
        chk("t1_done", done, 1);
        chk("t1_run_en", run_en, 1);

        img = '{16'hA001, 16'hB002};
        run_frame(8'h01, 8'h00, 0, 1'b0);
        chk("t2_error", error, 1);
        repeat (4) @(posedge clock);
        #1;
        chk("t2_run_en_held", run_en, 0);
        chk("t2_done_held", done, 1);

        img.delete();
        for (int i = 0; i < 64; i++) img.push_back({i[7:0], ~i[7:0]});
        run_frame(8'h3F, 8'h00, 0, 1'b0);
        chk("t3_error", error, 0);
        chk("t3_last_addr", wr_addr, 63);

        img = '{16'h1111, 16'h2233, 16'h4455};
        run_frame(8'hC2, img_xor(3), 3, 1'b0);
        chk("t4_error", error, 0);

        img = '{16'hDEAD, 16'hBEEF};
        run_frame(8'h01, img_xor(2), 1, 1'b1);
        chk("t6_error", error, 0);

        // Reset after HI byte of the third word is accepted
        img = '{16'h0102, 16'h0304, 16'h0506};
        do_start();
        send_byte(8'h05, 0);
        for (int i = 0; i < 2; i++) begin
            wq.push_back({i[5:0], img[i]});
            send_byte(img[i][15:8], 0);
            send_byte(img[i][7:0], 0);
        end
        send_byte(8'h05, 0);
        snap = wr_seen;
        chk("mid_writes", snap, wr_seen > 0 ? 2 + (snap - 2) : 0);
        reset = 1'b0;
        #1;
        check_reset_vals();
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        chk("mid_no_third_wr", wr_seen, snap);
        chk("mid_wq", wq.size(), 0);
        wq.delete();
        eq.delete();
        img = '{16'hCAFE, 16'h0042};
        run_frame(8'h01, img_xor(2), 0, 1'b0);
        chk("reload_error", error, 0);

        for (int k = 0; k < 8; k++) begin
            n = (k == 7) ? 64 : $urandom_range(1, 10);
            img.delete();
            for (int i = 0; i < n; i++) img.push_back(16'($urandom));
            h = {2'($urandom), 6'(n - 1)};
            run_frame(h, img_xor(n) ^ (($urandom_range(0, 2) == 0) ? 8'h5A : 8'h00),
                      $urandom_range(0, 2), $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
